// File: rtl/pushbutton_gesture_pkg.sv
// pushbutton_gesture_pkg: shared types and helpers for the
// pushbutton gesture decoder.
package pushbutton_gesture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_GAP    = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_LONG   = 3'd4
  } pushbutton_gesture_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pushbutton.sv
// pushbutton: synchronizer plus hold-time debounce for a raw
// button level, with a debounced level and a press toggle.
module pushbutton
  import pushbutton_gesture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 31,
  parameter int N_SYNC          = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cg,
  input  logic i_button,
  output logic o_held,
  output logic o_toggle
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [N_SYNC-1:0] sync_q;
  logic [DW-1:0]     cnt_q;
  logic              held_q;
  logic              toggle_q;
  logic              sync_bit;

  assign sync_bit = sync_q[N_SYNC-1];

  // sync the pin, then accept a new level once it has been
  // seen DEBOUNCE_CYCLES+1 consecutive cycles
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      held_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else if (i_cg) begin
      sync_q <= {sync_q[N_SYNC-2:0], i_button};
      if (sync_bit == held_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DW'(DEBOUNCE_CYCLES)) begin
        cnt_q    <= '0;
        held_q   <= sync_bit;
        toggle_q <= toggle_q ^ sync_bit;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign o_held   = held_q;
  assign o_toggle = toggle_q;

endmodule

// File: rtl/pushbutton_gesture.sv
// pushbutton_gesture: click / double click / long press decoder.
// Define PUSHBUTTON_GESTURE_REPEAT_EN to build the auto-repeat.
module pushbutton_gesture
  import pushbutton_gesture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 31,
  parameter int N_SYNC          = 2,
  parameter int LONG_CYCLES     = 1000,
  parameter int GAP_CYCLES      = 200,
  parameter int REPEAT_CYCLES   = 250
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cg,
  input  logic       i_button,
  output logic       o_held,
  output logic       o_click,
  output logic       o_doubleClick,
  output logic       o_longPress,
  output logic       o_repeat,
  output logic [2:0] o_state
);

`ifdef PUSHBUTTON_GESTURE_REPEAT_EN
  localparam int CNT_MAX =
    max3(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES);
`else
  localparam int CNT_MAX =
    max3(LONG_CYCLES, GAP_CYCLES, 0);
  // repeat period has no effect in this build
  localparam int REPEAT_UNUSED = REPEAT_CYCLES;
`endif
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] LONG_END = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYCLES - 1);

  pushbutton_gesture_state_t state_q, state_d;
  logic [CW-1:0] cntr_q, cntr_d;
  logic deb, deb_prev_q, rise, fall;
  logic click_d, dbl_d, long_d, wrap;
  logic click_q, dbl_pend_q, dbl_q, long_q;
  logic unused_toggle;

  pushbutton #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .N_SYNC         (N_SYNC)
  ) u_pushbutton (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_cg    (i_cg),
    .i_button(i_button),
    .o_held  (deb),
    .o_toggle(unused_toggle)
  );

  assign rise = deb & ~deb_prev_q;
  assign fall = ~deb & deb_prev_q;

`ifdef PUSHBUTTON_GESTURE_REPEAT_EN
  localparam logic [CW-1:0] REP_END = CW'(REPEAT_CYCLES - 1);
  logic rep_d, rep_q;
`endif

  // gesture transitions and pulse requests
  always_comb begin
    state_d = state_q;
    click_d = 1'b0;
    dbl_d   = 1'b0;
    long_d  = 1'b0;
    wrap    = 1'b0;
`ifdef PUSHBUTTON_GESTURE_REPEAT_EN
    rep_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (fall) begin
          state_d = ST_GAP;
        end else if (cntr_q == LONG_END) begin
          long_d  = 1'b1;
          state_d = ST_LONG;
        end
      end
      ST_GAP: begin
        if (rise) begin
          state_d = ST_PRESS2;
        end else if (cntr_q == GAP_END) begin
          click_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_PRESS2: begin
        if (fall) begin
          dbl_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_LONG: begin
        if (fall) begin
          state_d = ST_IDLE;
`ifdef PUSHBUTTON_GESTURE_REPEAT_EN
        end else if (cntr_q == REP_END) begin
          wrap  = 1'b1;
          rep_d = 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // shared counter: restarts on any state change or repeat wrap
  always_comb begin
    cntr_d = cntr_q;
    if (state_d != state_q || wrap) begin
      cntr_d = '0;
    end else if (cntr_q != {CW{1'b1}}) begin
      cntr_d = cntr_q + 1'b1;
    end
  end

  // state, counter, edge history and pulse registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cntr_q     <= '0;
      deb_prev_q <= 1'b0;
      click_q    <= 1'b0;
      dbl_pend_q <= 1'b0;
      dbl_q      <= 1'b0;
      long_q     <= 1'b0;
    end else if (i_cg) begin
      state_q    <= state_d;
      cntr_q     <= cntr_d;
      deb_prev_q <= deb;
      click_q    <= click_d;
      // double click retimed to land two cycles after release
      dbl_pend_q <= dbl_d;
      dbl_q      <= dbl_pend_q;
      long_q     <= long_d;
    end
  end

`ifdef PUSHBUTTON_GESTURE_REPEAT_EN
  // auto-repeat pulse register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rep_q <= 1'b0;
    end else if (i_cg) begin
      rep_q <= rep_d;
    end
  end
  assign o_repeat = rep_q;
`else
  assign o_repeat = 1'b0;
`endif

  assign o_held        = deb;
  assign o_click       = click_q;
  assign o_doubleClick = dbl_q;
  assign o_longPress   = long_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_pushbutton_gesture.sv
// tb_pushbutton_gesture: random and directed stimulus against a
// timeline model of the gesture rules.
module tb_pushbutton_gesture;

  localparam int DEB  = 3;
  localparam int NS   = 2;
  localparam int LONG = 20;
  localparam int GAP  = 10;
  localparam int REP  = 5;
  localparam int HL   = NS + DEB + 1;
`ifdef PUSHBUTTON_GESTURE_REPEAT_EN
  localparam int REP_N = 3;
`else
  localparam int REP_N = 0;
`endif

  localparam int M_WAIT  = 0;
  localparam int M_DOWN1 = 1;
  localparam int M_UP1   = 2;
  localparam int M_DOWN2 = 3;
  localparam int M_HOLD  = 4;

  logic clk = 1'b0;
  logic rst, cg, button;
  logic o_held, o_click, o_doubleClick, o_longPress, o_repeat;
  logic [2:0] o_state;

  pushbutton_gesture #(
    .DEBOUNCE_CYCLES(DEB),
    .N_SYNC         (NS),
    .LONG_CYCLES    (LONG),
    .GAP_CYCLES     (GAP),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cg         (cg),
    .i_button     (button),
    .o_held       (o_held),
    .o_click      (o_click),
    .o_doubleClick(o_doubleClick),
    .o_longPress  (o_longPress),
    .o_repeat     (o_repeat),
    .o_state      (o_state)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: input history, debounced level, gesture timeline
  bit hist[HL];
  bit m_held;
  int s = 0;
  int phase, t0, tf, tnext, dbl_at;
  bit e_click, e_dbl, e_long, e_rep;

  // observation counters
  bit prev_held;
  int h_rise, h_fall, t_lr;
  int n_click, n_dbl, n_long, n_rep, n_hrise;

  task automatic model_reset();
    foreach (hist[i]) hist[i] = 1'b0;
    m_held  = 1'b0;
    phase   = M_WAIT;
    dbl_at  = -1;
    e_click = 1'b0;
    e_dbl   = 1'b0;
    e_long  = 1'b0;
    e_rep   = 1'b0;
    prev_held = 1'b0;
  endtask

  task automatic model_step(input bit b);
    bit hp, nh, same;
    s++;
    for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = b;
    same = 1'b1;
    for (int i = NS; i <= NS + DEB; i++)
      if (hist[i] != hist[NS]) same = 1'b0;
    hp = m_held;
    nh = (same && hist[NS] != m_held) ? hist[NS] : m_held;
    m_held  = nh;
    e_click = 1'b0;
    e_dbl   = (s == dbl_at);
    e_long  = 1'b0;
    e_rep   = 1'b0;
    if (phase == M_DOWN1 && s == t0 + LONG + 1) begin
      e_long = 1'b1;
      phase  = M_HOLD;
      tnext  = s + REP;
    end else if (phase == M_UP1 && s == tf + GAP + 1) begin
      e_click = 1'b1;
      phase   = M_WAIT;
    end
`ifdef PUSHBUTTON_GESTURE_REPEAT_EN
    else if (phase == M_HOLD && s == tnext) begin
      e_rep = 1'b1;
      tnext = tnext + REP;
    end
`endif
    if (nh && !hp) begin
      if (phase == M_WAIT) begin
        phase = M_DOWN1;
        t0    = s;
      end else if (phase == M_UP1) begin
        phase = M_DOWN2;
      end
    end
    if (!nh && hp) begin
      if (phase == M_DOWN1) begin
        phase = M_UP1;
        tf    = s;
      end else if (phase == M_DOWN2) begin
        dbl_at = s + 2;
        phase  = M_WAIT;
      end else if (phase == M_HOLD) begin
        phase = M_WAIT;
      end
    end
  endtask

  task automatic cyc(input bit b, input bit en);
    button = b;
    cg     = en;
    @(posedge clk);
    #1;
    if (en) model_step(b);
    chk("out", {o_held, o_click, o_doubleClick, o_longPress, o_repeat},
        {m_held, e_click, e_dbl, e_long, e_rep});
    if (en) begin
      if (o_held && !prev_held) begin
        h_rise = s;
        n_hrise++;
      end
      if (!o_held && prev_held) h_fall = s;
      prev_held = o_held;
      if (o_click) begin
        n_click++;
        chk("click_lat", s - h_fall, GAP + 1);
      end
      if (o_doubleClick) begin
        n_dbl++;
        chk("dbl_lat", s - h_fall, 2);
      end
      if (o_longPress) begin
        n_long++;
        chk("long_lat", s - h_rise, LONG + 1);
        t_lr = s;
      end
      if (o_repeat) begin
        n_rep++;
        chk("rep_lat", s - t_lr, REP);
        t_lr = s;
      end
    end
  endtask

  task automatic seg(input bit b, input int n);
    repeat (n) cyc(b, 1'b1);
  endtask

  task automatic do_reset(input bit b);
    cg     = 1'b1;
    button = b;
    rst    = 1'b1;
    #1;
    chk("rst_async",
        {o_state, o_click, o_doubleClick, o_longPress, o_repeat}, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", {o_state, o_held, o_click, o_doubleClick,
                    o_longPress, o_repeat}, 0);
    rst = 1'b0;
    model_reset();
  endtask

  int c0, d0, l0, r0, hr0;

  task automatic snap();
    c0 = n_click; d0 = n_dbl; l0 = n_long; r0 = n_rep; hr0 = n_hrise;
  endtask

  task automatic counts(input string tag, input int c, input int d,
                        input int l, input int r);
    chk(tag, {8'(n_click - c0), 8'(n_dbl - d0), 8'(n_long - l0),
              8'(n_rep - r0)}, {8'(c), 8'(d), 8'(l), 8'(r)});
  endtask

  initial begin
    int k;
    bit lvl;
    n_click = 0; n_dbl = 0; n_long = 0; n_rep = 0; n_hrise = 0;
    h_rise = 0; h_fall = 0; t_lr = 0;
    rst = 1'b1; cg = 1'b1; button = 1'b0;
    model_reset();
    #2;
    do_reset(1'b0);
    seg(0, 10);

    snap(); seg(1, 8); seg(0, 30);
    counts("single_click", 1, 0, 0, 0);

    snap(); seg(1, 8); seg(0, 5); seg(1, 8); seg(0, 30);
    counts("double_click", 0, 1, 0, 0);

    snap(); seg(1, 40); seg(0, 30);
    counts("long_press", 0, 0, 1, REP_N);

    snap(); seg(1, 21); seg(0, 30);
    counts("long_edge", 0, 0, 1, 0);

    snap(); seg(1, 20); seg(0, 30);
    counts("release_at_long", 1, 0, 0, 0);

    snap(); seg(1, 8); seg(0, 10); seg(1, 8); seg(0, 30);
    counts("press_at_gap_end", 0, 1, 0, 0);

    snap(); seg(1, 8); seg(0, 11); seg(1, 8); seg(0, 30);
    counts("press_after_gap", 2, 0, 0, 0);

    snap();
    repeat (10) begin seg(1, 1); seg(0, 3); end
    seg(1, 2); seg(0, 20);
    counts("glitch", 0, 0, 0, 0);
    chk("glitch_held", n_hrise - hr0, 0);

    snap(); seg(1, 8); seg(0, 5); seg(1, 8);
    chk("in_press2", o_state, 3);
    do_reset(1'b0); seg(0, 30);
    counts("rst_press2", 0, 0, 0, 0);

    snap(); seg(1, 8);
    k = 0;
    while (!(phase == M_UP1 && s == tf + GAP) && k < 40) begin
      cyc(0, 1'b1);
      k++;
    end
    chk("gap_reach", k < 40, 1);
    chk("in_gap_end", o_state, 2);
    do_reset(1'b0); seg(0, 30);
    counts("rst_gap", 0, 0, 0, 0);

    lvl = 1'b0;
    for (int n = 0; n < 400; n++) begin
      int r, len;
      lvl = ~lvl;
      r = $urandom_range(0, 9);
      if (r < 2) len = $urandom_range(1, 3);
      else if (r < 7) len = $urandom_range(4, 25);
      else len = $urandom_range(15, 45);
      repeat (len) cyc(lvl, $urandom_range(0, 15) != 0);
      if ($urandom_range(0, 49) == 0) do_reset(1'($urandom_range(0, 1)));
    end
    seg(0, 40);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
